// File: rtl/ddr3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_ctrl
// Description : DDR3 SDRAM power-up initialization and periodic auto-refresh
//               sequencer. Walks RESET#, CKE, MR2, MR3, MR1, MR0 and ZQCL,
//               then issues REF every tREFI and reports init_done / ref_busy.
//               Define DDR3_SIM_FAST_EN to shorten the RESET# and CKE waits
//               for simulation.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_ctrl #(
    parameter int CLK_PERIOD = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ddr_clk,
    output logic        ddr_ck,
    output logic        ddr_ck_n,
    output logic        ddr_reset_n,
    output logic        ddr_cke,
    output logic        ddr_cs_n,
    output logic        ddr_ras_n,
    output logic        ddr_cas_n,
    output logic        ddr_we_n,
    output logic [2:0]  ddr_ba,
    output logic [13:0] ddr_addr,
    output logic        init_done,
    output logic        ref_busy
);

    // Convert a delay in ns to a whole number of clk cycles, rounding up.
    function automatic int ns2cyc(input int ns);
        return (ns + CLK_PERIOD - 1) / CLK_PERIOD;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

`ifdef DDR3_SIM_FAST_EN
    localparam int c_t_rst_ns = 2000;
    localparam int c_t_cke_ns = 5000;
`else
    localparam int c_t_rst_ns = 200000;
    localparam int c_t_cke_ns = 500000;
`endif

    localparam int c_t_rst  = ns2cyc(c_t_rst_ns);
    localparam int c_t_cke  = ns2cyc(c_t_cke_ns);
    localparam int c_t_xpr  = max_i(ns2cyc(170), 5);
    localparam int c_t_mrd  = 4;
    localparam int c_t_mod  = 12;
    localparam int c_t_zq   = 512;
    localparam int c_t_refi = ns2cyc(7800);
    localparam int c_t_rfc  = ns2cyc(160);

    // One counter times every wait; never narrower than 17 bits.
    localparam int c_t_max   = max_i(max_i(c_t_rst, c_t_cke), max_i(c_t_zq, c_t_refi));
    localparam int c_cnt_raw = $clog2(c_t_max + 1);
    localparam int c_cnt_w   = (c_cnt_raw < 17) ? 17 : c_cnt_raw;

    localparam logic [c_cnt_w-1:0] c_ld_rst  = c_cnt_w'(c_t_rst - 1);
    localparam logic [c_cnt_w-1:0] c_ld_cke  = c_cnt_w'(c_t_cke - 1);
    localparam logic [c_cnt_w-1:0] c_ld_xpr  = c_cnt_w'(c_t_xpr - 1);
    localparam logic [c_cnt_w-1:0] c_ld_mrd  = c_cnt_w'(c_t_mrd - 1);
    localparam logic [c_cnt_w-1:0] c_ld_mod  = c_cnt_w'(c_t_mod - 1);
    localparam logic [c_cnt_w-1:0] c_ld_zq   = c_cnt_w'(c_t_zq - 1);
    localparam logic [c_cnt_w-1:0] c_ld_refi = c_cnt_w'(c_t_refi - 1);
    // After REF the interval is measured from the REF command, so the IDLE
    // stretch excludes the tRFC already spent in REF.
    localparam logic [c_cnt_w-1:0] c_ld_gap  = c_cnt_w'(c_t_refi - c_t_rfc - 1);
    localparam logic [c_cnt_w-1:0] c_ld_rfc  = c_cnt_w'(c_t_rfc - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] c_cmd_nop  = 4'b0111;
    localparam logic [3:0] c_cmd_mrs  = 4'b0000;
    localparam logic [3:0] c_cmd_ref  = 4'b0001;
    localparam logic [3:0] c_cmd_zqcl = 4'b0110;

    typedef enum logic [3:0] {
        ST_RST_WAIT = 4'd0,
        ST_CKE_WAIT = 4'd1,
        ST_XPR      = 4'd2,
        ST_MR2      = 4'd3,
        ST_MR3      = 4'd4,
        ST_MR1      = 4'd5,
        ST_MR0      = 4'd6,
        ST_ZQCL     = 4'd7,
        ST_IDLE     = 4'd8,
        ST_REF      = 4'd9
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_first;
    logic                 w_expire;
    logic [3:0]           w_cmd;
    logic [2:0]           w_ba;
    logic [13:0]          w_addr;

    logic                 r_reset_n;
    logic                 r_cke;
    logic [3:0]           r_cmd;
    logic [2:0]           r_ba;
    logic [13:0]          r_addr;
    logic                 r_init_done;
    logic                 r_ref_busy;

    assign w_expire = (r_cnt == '0);

    // Next state, counter reload and the command for the first cycle of a state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - c_cnt_one;
        w_cmd       = c_cmd_nop;
        w_ba        = 3'd0;
        w_addr      = 14'd0;
        case (r_state)
            ST_RST_WAIT: if (w_expire) begin w_state_nxt = ST_CKE_WAIT; w_cnt_nxt = c_ld_cke; end
            ST_CKE_WAIT: if (w_expire) begin w_state_nxt = ST_XPR;      w_cnt_nxt = c_ld_xpr; end
            ST_XPR:      if (w_expire) begin w_state_nxt = ST_MR2;      w_cnt_nxt = c_ld_mrd; end
            ST_MR2: begin
                if (r_first) begin w_cmd = c_cmd_mrs; w_ba = 3'd2; w_addr = 14'h0000; end
                if (w_expire) begin w_state_nxt = ST_MR3; w_cnt_nxt = c_ld_mrd; end
            end
            ST_MR3: begin
                if (r_first) begin w_cmd = c_cmd_mrs; w_ba = 3'd3; w_addr = 14'h0000; end
                if (w_expire) begin w_state_nxt = ST_MR1; w_cnt_nxt = c_ld_mrd; end
            end
            ST_MR1: begin
                if (r_first) begin w_cmd = c_cmd_mrs; w_ba = 3'd1; w_addr = 14'h0004; end
                if (w_expire) begin w_state_nxt = ST_MR0; w_cnt_nxt = c_ld_mod; end
            end
            ST_MR0: begin
                if (r_first) begin w_cmd = c_cmd_mrs; w_ba = 3'd0; w_addr = 14'h0520; end
                if (w_expire) begin w_state_nxt = ST_ZQCL; w_cnt_nxt = c_ld_zq; end
            end
            ST_ZQCL: begin
                if (r_first) begin w_cmd = c_cmd_zqcl; w_addr = 14'h0400; end
                if (w_expire) begin w_state_nxt = ST_IDLE; w_cnt_nxt = c_ld_refi; end
            end
            ST_IDLE:     if (w_expire) begin w_state_nxt = ST_REF;      w_cnt_nxt = c_ld_rfc; end
            ST_REF: begin
                if (r_first) w_cmd = c_cmd_ref;
                if (w_expire) begin w_state_nxt = ST_IDLE; w_cnt_nxt = c_ld_gap; end
            end
            default: begin w_state_nxt = ST_RST_WAIT; w_cnt_nxt = c_ld_rst; end
        endcase
    end

    // State, wait counter and registered pin drivers; pins lag the state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RST_WAIT;
            r_cnt       <= c_ld_rst;
            r_first     <= 1'b1;
            r_reset_n   <= 1'b0;
            r_cke       <= 1'b0;
            r_cmd       <= c_cmd_nop | 4'b1000;
            r_ba        <= 3'd0;
            r_addr      <= 14'd0;
            r_init_done <= 1'b0;
            r_ref_busy  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_first     <= (w_state_nxt != r_state);
            r_reset_n   <= (r_state != ST_RST_WAIT);
            r_cke       <= (r_state != ST_RST_WAIT) && (r_state != ST_CKE_WAIT);
            r_cmd       <= w_cmd;
            r_ba        <= w_ba;
            r_addr      <= w_addr;
            r_init_done <= (r_state == ST_IDLE) || (r_state == ST_REF);
            r_ref_busy  <= (r_state == ST_REF);
        end
    end

    assign ddr_ck      = ddr_clk;
    assign ddr_ck_n    = ~ddr_clk;
    assign ddr_reset_n = r_reset_n;
    assign ddr_cke     = r_cke;
    assign ddr_cs_n    = r_cmd[3];
    assign ddr_ras_n   = r_cmd[2];
    assign ddr_cas_n   = r_cmd[1];
    assign ddr_we_n    = r_cmd[0];
    assign ddr_ba      = r_ba;
    assign ddr_addr    = r_addr;
    assign init_done   = r_init_done;
    assign ref_busy    = r_ref_busy;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_ctrl
// Description : Self-checking bench for ddr3_ctrl. A timeline model gives the
//               expected pins for every cycle counted from reset release;
//               reset is re-asserted at random points mid-MRS and mid-REF.
//               Honours DDR3_SIM_FAST_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_ctrl;

    localparam int CLK_PERIOD = 10;

`ifdef DDR3_SIM_FAST_EN
    localparam int c_fast  = 1;
    localparam int c_t_rst = 200;     // 2000 ns
    localparam int c_t_cke = 500;     // 5000 ns
`else
    localparam int c_fast  = 0;
    localparam int c_t_rst = 20000;   // 200000 ns
    localparam int c_t_cke = 50000;   // 500000 ns
`endif
    localparam int c_t_xpr  = 17;     // ceil(170/10), above the 5-cycle floor
    localparam int c_t_mrd  = 4;
    localparam int c_t_mod  = 12;
    localparam int c_t_zq   = 512;
    localparam int c_t_refi = 780;
    localparam int c_t_rfc  = 16;

    // Cycle (counted from the first un-reset edge, 0-based) each event shows on the pins.
    localparam int c_at_mr2  = c_t_rst + c_t_cke + c_t_xpr;
    localparam int c_at_zq   = c_at_mr2 + 3 * c_t_mrd + c_t_mod;
    localparam int c_at_done = c_at_zq + c_t_zq;
    localparam int c_at_ref0 = c_at_done + c_t_refi;

    typedef struct packed {
        logic        rst_n;
        logic        cke;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic        done;
        logic        busy;
    } pins_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ddr_clk = 1'b0;
    logic        ddr_ck, ddr_ck_n, ddr_reset_n, ddr_cke;
    logic        ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
    logic [2:0]  ddr_ba;
    logic [13:0] ddr_addr;
    logic        init_done, ref_busy;

    int n_cmp = 0;
    int n_err = 0;
    int rel   = -1;

    ddr3_ctrl #(.CLK_PERIOD(CLK_PERIOD)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .ddr_clk    (ddr_clk),
        .ddr_ck     (ddr_ck),
        .ddr_ck_n   (ddr_ck_n),
        .ddr_reset_n(ddr_reset_n),
        .ddr_cke    (ddr_cke),
        .ddr_cs_n   (ddr_cs_n),
        .ddr_ras_n  (ddr_ras_n),
        .ddr_cas_n  (ddr_cas_n),
        .ddr_we_n   (ddr_we_n),
        .ddr_ba     (ddr_ba),
        .ddr_addr   (ddr_addr),
        .init_done  (init_done),
        .ref_busy   (ref_busy)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at rel=%0d: got 0x%0h, want 0x%0h", tag, rel, obs, exp);
        end
    endtask

    // Expected pins r cycles after release (r < 0 means held in reset).
    function automatic pins_t model(input int r);
        pins_t p;
        int    ph;
        p      = '0;
        p.cmd  = 4'b1111;
        if (r < 0) return p;
        p.cmd   = 4'b0111;
        p.rst_n = (r >= c_t_rst);
        p.cke   = (r >= c_t_rst + c_t_cke);
        if (r >= c_at_mr2 && r < c_at_mr2 + 4 * c_t_mrd && ((r - c_at_mr2) % c_t_mrd) == 0) begin
            p.cmd = 4'b0000;
            case ((r - c_at_mr2) / c_t_mrd)
                0: begin p.ba = 3'd2; p.addr = 14'h0000; end
                1: begin p.ba = 3'd3; p.addr = 14'h0000; end
                2: begin p.ba = 3'd1; p.addr = 14'h0004; end
                default: begin p.ba = 3'd0; p.addr = 14'h0520; end
            endcase
        end
        if (r == c_at_zq) begin
            p.cmd  = 4'b0110;
            p.addr = 14'h0400;
        end
        p.done = (r >= c_at_done);
        if (r >= c_at_ref0) begin
            ph     = (r - c_at_ref0) % c_t_refi;
            p.busy = (ph < c_t_rfc);
            if (ph == 0) p.cmd = 4'b0001;
        end
        return p;
    endfunction

    // Advance one clk, then compare every pin against the model.
    task automatic step();
        pins_t e;
        logic  inv;
        @(posedge clk);
        #1;
        if (reset) rel = -1;
        else       rel = rel + 1;
        ddr_clk = 1'($urandom_range(0, 1));
        #1;
        inv = ~ddr_clk;
        e   = model(rel);
        check("reset_n",   ddr_reset_n, e.rst_n);
        check("cke",       ddr_cke, e.cke);
        check("cmd",       {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}, e.cmd);
        check("ba",        ddr_ba, e.ba);
        check("addr",      ddr_addr, e.addr);
        check("init_done", init_done, e.done);
        check("ref_busy",  ref_busy, e.busy);
        check("ck",        ddr_ck, ddr_clk);
        check("ck_n",      ddr_ck_n, inv);
    endtask

    initial begin
        int stop;
        reset = 1'b1;
        repeat (20) step();
        reset = 1'b0;

        // First interruption: inside the MRS/ZQCL sequence (only reachable
        // within budget in the fast build; otherwise inside the RESET# wait).
        if (c_fast != 0) stop = c_at_mr2 + $urandom_range(0, 3 * c_t_mrd + c_t_mod - 1);
        else             stop = $urandom_range(100, c_t_rst - 1);
        while (rel < stop) step();
        reset = 1'b1;
        repeat ($urandom_range(1, 5)) step();
        reset = 1'b0;

        // Full init, three complete refresh periods, then reset during the fourth tRFC.
        stop = c_at_ref0 + 3 * c_t_refi + $urandom_range(0, c_t_rfc - 1);
        while (rel < stop) step();
        reset = 1'b1;
        repeat ($urandom_range(1, 4)) step();
        reset = 1'b0;

        // Restart from RST_WAIT.
        if (c_fast != 0) stop = c_at_zq + 20;
        else             stop = 1000;
        while (rel < stop) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
